regfile_sb: RTL and testbench

Parametrised successor to the RV32IM register file for the pipelined RV32IM core. Has two synchronous write ports: port 0 for ALU/load writeback and port 1 for long-latency MUL/DIV writeback. Has two asynchronous read ports. Has an integrated per-register busy scoreboard, so decode stalls on RAW/WAW hazards against in-flight multi-cycle results.

---
 rtl/regfile_sb_if.sv | 37 +++
 rtl/regfile_sb.sv | 90 +++++++++
 tb/tb_regfile_sb.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// Bundles the register file write, issue and read signals.
// The master drives requests and the slave (the register file) returns read data and scoreboard state.
interface regfile_sb_if #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGISTER = 32
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGISTER);

  logic                    i_we0;
  logic [ADDR_WIDTH-1:0]   i_rd0_addr;
  logic [DATA_WIDTH-1:0]   i_rd0;
  logic                    i_we1;
  logic [ADDR_WIDTH-1:0]   i_rd1_addr;
  logic [DATA_WIDTH-1:0]   i_rd1;
  logic                    i_issue;
  logic [ADDR_WIDTH-1:0]   i_issue_addr;
  logic [ADDR_WIDTH-1:0]   i_rs1_addr;
  logic [ADDR_WIDTH-1:0]   i_rs2_addr;
  logic [DATA_WIDTH-1:0]   o_rs1;
  logic [DATA_WIDTH-1:0]   o_rs2;
  logic                    o_rs1_busy;
  logic                    o_rs2_busy;
  logic [NUM_REGISTER-1:0] o_busy_vec;
  logic                    o_err;

  modport master (
    output i_we0, i_rd0_addr, i_rd0, i_we1, i_rd1_addr, i_rd1,
           i_issue, i_issue_addr, i_rs1_addr, i_rs2_addr,
    input  o_rs1, o_rs2, o_rs1_busy, o_rs2_busy, o_busy_vec, o_err
  );

  modport slave (
    input  i_we0, i_rd0_addr, i_rd0, i_we1, i_rd1_addr, i_rd1,
           i_issue, i_issue_addr, i_rs1_addr, i_rs2_addr,
    output o_rs1, o_rs2, o_rs1_busy, o_rs2_busy, o_busy_vec, o_err
  );
endinterface

// File: rtl/regfile_sb.sv
// Two-write/two-read register file with a per-register busy scoreboard for multi-cycle results.
// Optional macro REGFILE_FORWARD_EN adds same-cycle write-to-read bypass and busy masking.
module regfile_sb #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGISTER = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  regfile_sb_if.slave  bus
);
  localparam int ADDR_WIDTH = $clog2(NUM_REGISTER);

  logic [DATA_WIDTH-1:0]   r_regs [NUM_REGISTER];
  logic [NUM_REGISTER-1:0] r_busy;
  logic [NUM_REGISTER-1:0] w_busy_next;
  logic                    r_err;
  logic                    w_err_next;
  logic                    w_we0_ok;
  logic                    w_we1_ok;
  logic                    w_issue_ok;

  assign w_we0_ok   = bus.i_we0   && (bus.i_rd0_addr   != '0);
  assign w_we1_ok   = bus.i_we1   && (bus.i_rd1_addr   != '0);
  assign w_issue_ok = bus.i_issue && (bus.i_issue_addr != '0);

  // A reissue to a register retired in the same cycle is a legal back-to-back op, not a WAW error.
  always_comb begin
    w_busy_next = r_busy;
    if (w_we1_ok)
      w_busy_next[bus.i_rd1_addr] = 1'b0;
    if (w_issue_ok)
      w_busy_next[bus.i_issue_addr] = 1'b1;
    w_err_next = (w_we0_ok && w_we1_ok && (bus.i_rd0_addr == bus.i_rd1_addr))
               || (w_issue_ok && r_busy[bus.i_issue_addr]
                   && !(w_we1_ok && (bus.i_rd1_addr == bus.i_issue_addr)))
               || (w_we1_ok && !r_busy[bus.i_rd1_addr]);
  end

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGISTER; i++)
        r_regs[i] <= '0;
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_we0_ok)
        r_regs[bus.i_rd0_addr] <= bus.i_rd0;
      if (w_we1_ok)
        r_regs[bus.i_rd1_addr] <= bus.i_rd1;
      r_busy <= w_busy_next;
      r_err  <= w_err_next;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_data(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] data;
    data = r_regs[addr];
`ifdef REGFILE_FORWARD_EN
    if (w_we0_ok && (bus.i_rd0_addr == addr))
      data = bus.i_rd0;
    if (w_we1_ok && (bus.i_rd1_addr == addr))
      data = bus.i_rd1;
`endif
    if (addr == '0)
      data = '0;
    return data;
  endfunction

  function automatic logic read_busy(input logic [ADDR_WIDTH-1:0] addr);
    logic busy;
    busy = r_busy[addr];
`ifdef REGFILE_FORWARD_EN
    if (w_we1_ok && (bus.i_rd1_addr == addr))
      busy = 1'b0;
`endif
    if (addr == '0)
      busy = 1'b0;
    return busy;
  endfunction

  always_comb begin
    bus.o_rs1      = read_data(bus.i_rs1_addr);
    bus.o_rs2      = read_data(bus.i_rs2_addr);
    bus.o_rs1_busy = read_busy(bus.i_rs1_addr);
    bus.o_rs2_busy = read_busy(bus.i_rs2_addr);
    bus.o_busy_vec = r_busy;
    bus.o_err      = r_err;
  end
endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed scenarios plus randomized traffic against an array model.
// Honours REGFILE_FORWARD_EN when computing same-cycle read expectations.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_sb_if #(.DATA_WIDTH(DW), .NUM_REGISTER(NR)) bus ();
  regfile_sb #(.DATA_WIDTH(DW), .NUM_REGISTER(NR)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] m_mem [32];
  logic [31:0] m_busy;
  logic        m_err;

  task automatic idle();
    bus.i_we0 = 0; bus.i_rd0_addr = 0; bus.i_rd0 = 0;
    bus.i_we1 = 0; bus.i_rd1_addr = 0; bus.i_rd1 = 0;
    bus.i_issue = 0; bus.i_issue_addr = 0;
    bus.i_rs1_addr = 0; bus.i_rs2_addr = 0;
  endtask

  // Reference: architectural rules applied to the current inputs at a clock edge.
  task automatic model_edge();
    bit w0, w1, is, ill;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_mem[i] = 0;
      m_busy = 0;
      m_err  = 0;
      return;
    end
    w0 = bus.i_we0 && bus.i_rd0_addr != 0;
    w1 = bus.i_we1 && bus.i_rd1_addr != 0;
    is = bus.i_issue && bus.i_issue_addr != 0;
    ill = 0;
    if (w0 && w1 && bus.i_rd0_addr == bus.i_rd1_addr) ill = 1;
    if (is && m_busy[bus.i_issue_addr] && !(w1 && bus.i_rd1_addr == bus.i_issue_addr)) ill = 1;
    if (w1 && !m_busy[bus.i_rd1_addr]) ill = 1;
    if (w0) m_mem[bus.i_rd0_addr] = bus.i_rd0;
    if (w1) begin m_mem[bus.i_rd1_addr] = bus.i_rd1; m_busy[bus.i_rd1_addr] = 0; end
    if (is) m_busy[bus.i_issue_addr] = 1;
    m_err = ill;
  endtask

  function automatic logic [31:0] exp_rs(input logic [4:0] a);
    logic [31:0] v;
    v = m_mem[a];
`ifdef REGFILE_FORWARD_EN
    if (bus.i_we0 && bus.i_rd0_addr == a) v = bus.i_rd0;
    if (bus.i_we1 && bus.i_rd1_addr == a) v = bus.i_rd1;
`endif
    if (a == 0) v = 0;
    return v;
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic b;
    b = m_busy[a];
`ifdef REGFILE_FORWARD_EN
    if (bus.i_we1 && bus.i_rd1_addr == a) b = 0;
`endif
    if (a == 0) b = 0;
    return b;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    tick();
    rst = 0;
    bus.i_rs1_addr = 1; bus.i_rs2_addr = 31; #1;
    total++; if (bus.o_busy_vec !== 32'h0) begin bad++; $display("FAIL reset_busy_vec got=%h exp=0", bus.o_busy_vec); end
    total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus.o_err); end
    total++; if (bus.o_rs1 !== 32'h0 || bus.o_rs2 !== 32'h0) begin bad++; $display("FAIL reset_regs rs1=%h rs2=%h exp=0", bus.o_rs1, bus.o_rs2); end
    $display("reset: busy_vec=%h err=%b", bus.o_busy_vec, bus.o_err);
  endtask

  task automatic test_write_read();
    idle(); bus.i_we0 = 1; bus.i_rd0_addr = 1; bus.i_rd0 = 32'hDEADBEEF;
    tick();
    idle(); bus.i_rs1_addr = 1; bus.i_rs2_addr = 0; #1;
    total++; if (bus.o_rs1 !== 32'hDEADBEEF) begin bad++; $display("FAIL write_read_x1 got=%h exp=deadbeef", bus.o_rs1); end
    total++; if (bus.o_rs2 !== 32'h0) begin bad++; $display("FAIL read_x0 got=%h exp=0", bus.o_rs2); end
    $display("write x1: rs1=%h rs2=%h", bus.o_rs1, bus.o_rs2);
  endtask

  task automatic test_x0();
    idle(); bus.i_we0 = 1; bus.i_we1 = 1; bus.i_rd0 = 32'hFFFFFFFF; bus.i_rd1 = 32'hFFFFFFFF;
    tick();
    idle(); bus.i_rs1_addr = 0; #1;
    total++; if (bus.o_rs1 !== 32'h0) begin bad++; $display("FAIL x0_write got=%h exp=0", bus.o_rs1); end
    total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL x0_err got=%b exp=0", bus.o_err); end
    $display("write x0: rs1=%h err=%b", bus.o_rs1, bus.o_err);
  endtask

  task automatic test_scoreboard();
    idle(); bus.i_issue = 1; bus.i_issue_addr = 5;
    tick();
    idle(); bus.i_rs2_addr = 5; #1;
    total++; if (bus.o_rs2_busy !== 1'b1) begin bad++; $display("FAIL issue_busy got=%b exp=1", bus.o_rs2_busy); end
    total++; if (bus.o_busy_vec !== 32'h00000020) begin bad++; $display("FAIL issue_vec got=%h exp=00000020", bus.o_busy_vec); end
    bus.i_we1 = 1; bus.i_rd1_addr = 5; bus.i_rd1 = 32'h12345678; #1;
`ifdef REGFILE_FORWARD_EN
    total++; if (bus.o_rs2_busy !== 1'b0) begin bad++; $display("FAIL clear_mask got=%b exp=0", bus.o_rs2_busy); end
`else
    total++; if (bus.o_rs2_busy !== 1'b1) begin bad++; $display("FAIL clear_unmasked got=%b exp=1", bus.o_rs2_busy); end
`endif
    tick();
    idle(); bus.i_rs2_addr = 5; #1;
    total++; if (bus.o_rs2_busy !== 1'b0 || bus.o_busy_vec !== 32'h0) begin bad++; $display("FAIL clear_busy got=%b vec=%h exp=0", bus.o_rs2_busy, bus.o_busy_vec); end
    total++; if (bus.o_rs2 !== 32'h12345678) begin bad++; $display("FAIL port1_data got=%h exp=12345678", bus.o_rs2); end
    total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL clear_err got=%b exp=0", bus.o_err); end
    $display("scoreboard x5: rs2=%h busy=%b", bus.o_rs2, bus.o_rs2_busy);
  endtask

  task automatic test_collision();
    idle(); bus.i_we0 = 1; bus.i_rd0_addr = 3; bus.i_rd0 = 32'hAAAA0000;
    bus.i_we1 = 1; bus.i_rd1_addr = 3; bus.i_rd1 = 32'h5555FFFF;
    tick();
    idle(); bus.i_rs1_addr = 3; #1;
    total++; if (bus.o_rs1 !== 32'h5555FFFF) begin bad++; $display("FAIL collision_data got=%h exp=5555ffff", bus.o_rs1); end
    total++; if (bus.o_err !== 1'b1) begin bad++; $display("FAIL collision_err got=%b exp=1", bus.o_err); end
    tick();
    total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle got=%b exp=0", bus.o_err); end
    $display("collision x3: rs1=%h", bus.o_rs1);
    idle(); bus.i_issue = 1; bus.i_issue_addr = 7;
    tick();
    bus.i_we1 = 1; bus.i_rd1_addr = 7; bus.i_rd1 = 32'h77;
    tick();
    idle(); #1;
    total++; if (bus.o_busy_vec[7] !== 1'b1) begin bad++; $display("FAIL issue_clear_x7 got=%b exp=1", bus.o_busy_vec[7]); end
    total++; if (bus.o_err !== 1'b0) begin bad++; $display("FAIL reissue_err got=%b exp=0", bus.o_err); end
    bus.i_we1 = 1; bus.i_rd1_addr = 7; bus.i_rd1 = 32'h78;
    tick();
    idle();
    $display("issue+clear x7: vec=%h", bus.o_busy_vec);
  endtask

  task automatic test_reset_busy();
    idle(); bus.i_issue = 1; bus.i_issue_addr = 9;
    tick();
    idle(); #1;
    total++; if (bus.o_busy_vec !== 32'h00000200) begin bad++; $display("FAIL busy_x9 got=%h exp=00000200", bus.o_busy_vec); end
    rst = 1;
    tick();
    rst = 0; #1;
    total++; if (bus.o_busy_vec !== 32'h0) begin bad++; $display("FAIL midreset_vec got=%h exp=0", bus.o_busy_vec); end
    for (int i = 0; i < 32; i++) begin
      bus.i_rs1_addr = i[4:0]; #1;
      total++; if (bus.o_rs1 !== 32'h0) begin bad++; $display("FAIL midreset_x%0d got=%h exp=0", i, bus.o_rs1); end
    end
    idle(); bus.i_we1 = 1; bus.i_rd1_addr = 9; bus.i_rd1 = 32'h99;
    tick();
    idle(); bus.i_rs1_addr = 9; #1;
    total++; if (bus.o_err !== 1'b1) begin bad++; $display("FAIL stray_we1_err got=%b exp=1", bus.o_err); end
    total++; if (bus.o_rs1 !== 32'h99) begin bad++; $display("FAIL stray_we1_data got=%h exp=99", bus.o_rs1); end
    $display("reset while busy: vec=%h err=%b", bus.o_busy_vec, bus.o_err);
  endtask

  task automatic test_forward();
    logic [31:0] old;
    old = m_mem[4];
    idle(); bus.i_we0 = 1; bus.i_rd0_addr = 4; bus.i_rd0 = 32'hCAFEF00D; bus.i_rs1_addr = 4; #1;
`ifdef REGFILE_FORWARD_EN
    total++; if (bus.o_rs1 !== 32'hCAFEF00D) begin bad++; $display("FAIL fwd_pre got=%h exp=cafef00d", bus.o_rs1); end
`else
    total++; if (bus.o_rs1 !== old) begin bad++; $display("FAIL nofwd_pre got=%h exp=%h", bus.o_rs1, old); end
`endif
    tick();
    idle(); bus.i_rs1_addr = 4; #1;
    total++; if (bus.o_rs1 !== 32'hCAFEF00D) begin bad++; $display("FAIL fwd_post got=%h exp=cafef00d", bus.o_rs1); end
    $display("write x4: rs1=%h", bus.o_rs1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      bus.i_we0 = $urandom_range(0, 1);
      bus.i_rd0_addr = 5'($urandom_range(0, 7));
      bus.i_rd0 = $urandom;
      bus.i_we1 = ($urandom_range(0, 9) < 4);
      bus.i_rd1_addr = 5'($urandom_range(0, 7));
      bus.i_rd1 = $urandom;
      bus.i_issue = ($urandom_range(0, 9) < 3);
      bus.i_issue_addr = 5'($urandom_range(0, 7));
      bus.i_rs1_addr = 5'($urandom_range(0, 7));
      bus.i_rs2_addr = 5'($urandom_range(0, 7));
      #1;
      total++; if (bus.o_rs1 !== exp_rs(bus.i_rs1_addr)) begin bad++; $display("FAIL rnd_rs1 cyc=%0d got=%h exp=%h", c, bus.o_rs1, exp_rs(bus.i_rs1_addr)); end
      total++; if (bus.o_rs2 !== exp_rs(bus.i_rs2_addr)) begin bad++; $display("FAIL rnd_rs2 cyc=%0d got=%h exp=%h", c, bus.o_rs2, exp_rs(bus.i_rs2_addr)); end
      total++; if (bus.o_rs1_busy !== exp_busy(bus.i_rs1_addr) || bus.o_rs2_busy !== exp_busy(bus.i_rs2_addr)) begin
        bad++; $display("FAIL rnd_rs_busy cyc=%0d got=%b%b exp=%b%b", c, bus.o_rs1_busy, bus.o_rs2_busy, exp_busy(bus.i_rs1_addr), exp_busy(bus.i_rs2_addr));
      end
      tick();
      total++; if (bus.o_busy_vec !== m_busy) begin bad++; $display("FAIL rnd_vec cyc=%0d got=%h exp=%h", c, bus.o_busy_vec, m_busy); end
      total++; if (bus.o_err !== m_err) begin bad++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", c, bus.o_err, m_err); end
      $display("rnd %0d rst=%b we0=%b@%0d we1=%b@%0d iss=%b@%0d vec=%h err=%b", c, rst, bus.i_we0, bus.i_rd0_addr,
               bus.i_we1, bus.i_rd1_addr, bus.i_issue, bus.i_issue_addr, bus.o_busy_vec, bus.o_err);
    end
    rst = 0;
    idle();
  endtask

  initial begin
    rst = 1;
    idle();
    test_reset();
    test_write_read();
    test_x0();
    test_scoreboard();
    test_collision();
    test_reset_busy();
    test_forward();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
